// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the write-back register file:
// default widths, the hard-wired zero index and the write-data select encoding.
package wb_regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    typedef enum logic {
        WB_SEL_ALU = 1'b0,
        WB_SEL_MEM = 1'b1
    } wb_sel_e;

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// 2:1 write-back data select between the ALU result and load data.
module wb_mux
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] wb_data
);

    // Pick the write-back source; unknown encodings fall back to the ALU path.
    always_comb begin
        wb_data = alu_data;
        case (wb_sel_e'(sel))
            WB_SEL_MEM: wb_data = mem_data;
            WB_SEL_ALU: wb_data = alu_data;
            default:    wb_data = alu_data;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Two-read / one-write register file with write-through bypass, a registered
// forwarding record of the last committed write, and a commit counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [15:0]       wr_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_r [0:NUM_REGS-1];
    logic [DATA_W-1:0] wb_data_s;
    logic [DATA_W-1:0] rd_data_a_s;
    logic [DATA_W-1:0] rd_data_b_s;
    logic              wr_en_s;
    logic              commit_s;
    logic              fwd_valid_r;
    logic [ADDR_W-1:0] fwd_addr_r;
    logic [DATA_W-1:0] fwd_data_r;
    logic [15:0]       wr_count_r;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .sel      (mem_to_reg),
        .alu_data (alu_result),
        .mem_data (mem_data),
        .wb_data  (wb_data_s)
    );

    // Bypass ignores reset so reads keep reflecting the live write port.
    assign wr_en_s  = reg_write && (wr_addr != ZERO_IDX);
    assign commit_s = wr_en_s && !rst;

    // Asynchronous read ports with same-cycle write-through.
    always_comb begin
        rd_data_a_s = {DATA_W{1'b0}};
        rd_data_b_s = {DATA_W{1'b0}};
        if (wr_en_s && (rd_addr_a == wr_addr)) begin
            rd_data_a_s = wb_data_s;
        end else if (rd_addr_a == ZERO_IDX) begin
            rd_data_a_s = {DATA_W{1'b0}};
        end else begin
            rd_data_a_s = regs_r[rd_addr_a];
        end
        if (wr_en_s && (rd_addr_b == wr_addr)) begin
            rd_data_b_s = wb_data_s;
        end else if (rd_addr_b == ZERO_IDX) begin
            rd_data_b_s = {DATA_W{1'b0}};
        end else begin
            rd_data_b_s = regs_r[rd_addr_b];
        end
    end

    // Register array: clear on reset, otherwise commit the selected write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (commit_s) begin
            regs_r[wr_addr] <= wb_data_s;
        end
    end

    // Forwarding record and commit counter; address/data hold on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_r <= 1'b0;
            fwd_addr_r  <= {ADDR_W{1'b0}};
            fwd_data_r  <= {DATA_W{1'b0}};
            wr_count_r  <= 16'd0;
        end else begin
            fwd_valid_r <= commit_s;
            if (commit_s) begin
                fwd_addr_r <= wr_addr;
                fwd_data_r <= wb_data_s;
                wr_count_r <= wr_count_r + 16'd1;
            end
        end
    end

    assign wb_data   = wb_data_s;
    assign rd_data_a = rd_data_a_s;
    assign rd_data_b = rd_data_b_s;
    assign fwd_valid = fwd_valid_r;
    assign fwd_addr  = fwd_addr_r;
    assign fwd_data  = fwd_data_r;
    assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile using immediate assertions.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  wr_addr;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic [31:0] wb_data;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic [15:0] wr_count;

    int n_assert = 0;
    int n_fail   = 0;

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .wr_addr    (wr_addr),
        .alu_result (alu_result),
        .mem_data   (mem_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .wb_data    (wb_data),
        .fwd_valid  (fwd_valid),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data),
        .wr_count   (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        wr_addr    = 5'd0;
        alu_result = 32'h0;
        mem_data   = 32'h0;
        rd_addr_a  = 5'd0;
        rd_addr_b  = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state on every index of both ports
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            check("reset_rd_a", rd_data_a, 32'h0);
            check("reset_rd_b", rd_data_b, 32'h0);
        end
        check("reset_wr_count", {16'h0, wr_count}, 32'h0);
        check("reset_fwd_valid", {31'h0, fwd_valid}, 32'h0);

        // ALU write to r5 with same-cycle bypass on port a
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
        wr_addr    = 5'd5;
        alu_result = 32'h1234_5678;
        mem_data   = 32'h0BAD_0BAD;
        rd_addr_a  = 5'd5;
        rd_addr_b  = 5'd4;
        #1;
        check("bypass_a_r5", rd_data_a, 32'h1234_5678);
        check("no_bypass_b_r4", rd_data_b, 32'h0);
        check("wb_data_alu", wb_data, 32'h1234_5678);
        tick();
        reg_write = 1'b0;
        #1;
        check("r5_fwd_valid", {31'h0, fwd_valid}, 32'h1);
        check("r5_fwd_addr", {27'h0, fwd_addr}, 32'h5);
        check("r5_fwd_data", fwd_data, 32'h1234_5678);
        check("r5_wr_count", {16'h0, wr_count}, 32'h1);
        check("r5_array_read", rd_data_a, 32'h1234_5678);

        // Write to r0 is discarded
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        wr_addr    = 5'd0;
        mem_data   = 32'hDEAD_BEEF;
        rd_addr_a  = 5'd0;
        rd_addr_b  = 5'd0;
        #1;
        check("wb_data_mem", wb_data, 32'hDEAD_BEEF);
        check("r0_bypass_a", rd_data_a, 32'h0);
        check("r0_bypass_b", rd_data_b, 32'h0);
        tick();
        reg_write = 1'b0;
        #1;
        check("r0_read", rd_data_a, 32'h0);
        check("r0_fwd_valid", {31'h0, fwd_valid}, 32'h0);
        check("r0_fwd_addr_hold", {27'h0, fwd_addr}, 32'h5);
        check("r0_fwd_data_hold", fwd_data, 32'h1234_5678);
        check("r0_wr_count", {16'h0, wr_count}, 32'h1);

        // Back-to-back writes to r7, both ports reading r7
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
        wr_addr    = 5'd7;
        alu_result = 32'hA;
        rd_addr_a  = 5'd7;
        rd_addr_b  = 5'd7;
        tick();
        alu_result = 32'hB;
        #1;
        check("r7_second_a", rd_data_a, 32'hB);
        check("r7_second_b", rd_data_b, 32'hB);
        tick();
        reg_write = 1'b0;
        #1;
        check("r7_after_a", rd_data_a, 32'hB);
        check("r7_after_b", rd_data_b, 32'hB);
        check("r7_fwd_addr", {27'h0, fwd_addr}, 32'h7);
        check("r7_fwd_data", fwd_data, 32'hB);
        check("r7_wr_count", {16'h0, wr_count}, 32'h3);
        tick();
        check("r7_idle_fwd_valid", {31'h0, fwd_valid}, 32'h0);

        // Load-data commit to r9
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        wr_addr    = 5'd9;
        alu_result = 32'h1111_1111;
        mem_data   = 32'hCAFE_F00D;
        tick();
        reg_write = 1'b0;
        rd_addr_a = 5'd9;
        rd_addr_b = 5'd5;
        #1;
        check("r9_mem_read", rd_data_a, 32'hCAFE_F00D);
        check("r5_still", rd_data_b, 32'h1234_5678);
        check("r9_wr_count", {16'h0, wr_count}, 32'h4);

        // Reset with a concurrent write: bypass live, write ignored
        rst        = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
        wr_addr    = 5'd3;
        alu_result = 32'h55;
        rd_addr_a  = 5'd3;
        #1;
        check("rst_bypass_r3", rd_data_a, 32'h55);
        tick();
        rst       = 1'b0;
        reg_write = 1'b0;
        #1;
        check("rst_r3", rd_data_a, 32'h0);
        check("rst_r5", rd_data_b, 32'h0);
        check("rst_wr_count", {16'h0, wr_count}, 32'h0);
        check("rst_fwd_valid", {31'h0, fwd_valid}, 32'h0);
        check("rst_fwd_addr", {27'h0, fwd_addr}, 32'h0);
        check("rst_fwd_data", fwd_data, 32'h0);

        // First commit right after reset release
        reg_write  = 1'b1;
        wr_addr    = 5'd3;
        alu_result = 32'h77;
        tick();
        reg_write = 1'b0;
        #1;
        check("first_commit_r3", rd_data_a, 32'h77);
        check("first_commit_count", {16'h0, wr_count}, 32'h1);

        // Counter wrap: 65534 more commits reach FFFF, one more wraps to 0
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
        for (int k = 0; k < 65534; k++) begin
            wr_addr    = 5'(1 + (k % 31));
            alu_result = 32'(k);
            tick();
        end
        reg_write = 1'b0;
        #1;
        check("count_ffff", {16'h0, wr_count}, 32'h0000_FFFF);
        reg_write  = 1'b1;
        wr_addr    = 5'd12;
        alu_result = 32'h0BEE_F00D;
        tick();
        reg_write = 1'b0;
        rd_addr_a = 5'd12;
        #1;
        check("count_wrap", {16'h0, wr_count}, 32'h0);
        check("wrap_fwd_valid", {31'h0, fwd_valid}, 32'h1);
        check("wrap_r12", rd_data_a, 32'h0BEE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameters: DATA_W, default 32, datapath width; ADDR_W, default 5, register index width (2**ADDR_W registers).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 reg_write  input  1  write-back enable from the WB pipeline latch.
REQ-005 mem_to_reg  input  1  write-data select: 1 = mem_data, 0 = alu_result.
REQ-006 wr_addr  input  ADDR_W  destination register index.
REQ-007 alu_result  input  DATA_W  ALU result carried to WB.
REQ-008 mem_data  input  DATA_W  load data carried to WB.
REQ-009 rd_addr_a, rd_addr_b  input  ADDR_W each  decode-stage read indices.
REQ-010 rd_data_a, rd_data_b  output  DATA_W each  read data, combinational.
REQ-011 wb_data  output  DATA_W  selected write-back value, combinational.
REQ-012 fwd_valid  output  1  registered: previous cycle performed a committed write.
REQ-013 fwd_addr  output  ADDR_W  registered index of that write.
REQ-014 fwd_data  output  DATA_W  registered data of that write.
REQ-015 wr_count  output  16  registered count of committed writes.

Function
REQ-016 wb_data SHALL equal mem_data when mem_to_reg=1, else alu_result, regardless of reg_write.
REQ-017 A write SHALL commit at posedge clk when reg_write=1, wr_addr!=0 and rst=0: regs[wr_addr] <= wb_data.
REQ-018 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded and SHALL NOT count as committed.
REQ-019 Reads SHALL be asynchronous: rd_data_x = regs[rd_addr_x], 0 for index 0.
REQ-020 Write-through bypass: when reg_write=1, wr_addr!=0 and rd_addr_x==wr_addr in the same cycle, rd_data_x SHALL equal wb_data (zero-latency read-after-write).
REQ-021 Both read ports SHALL bypass independently; equal rd_addr_a and rd_addr_b SHALL return identical data.
REQ-022 fwd_valid/fwd_addr/fwd_data SHALL capture commit, wr_addr, wb_data at each posedge (1-cycle latency); fwd_valid SHALL be 0 after a non-committing cycle, fwd_addr/fwd_data then hold their previous values.
REQ-023 wr_count SHALL increment by 1 on each committed write and wrap 16'hFFFF -> 0.
REQ-024 Consecutive writes to the same index SHALL leave the last-written value; no write merging or ordering hazards internal to the block.
REQ-025 No stall or back-pressure: one write per cycle accepted unconditionally.

Reset
REQ-026 While rst=1 at posedge: all registers, fwd_valid, fwd_addr, fwd_data, wr_count SHALL clear to 0, and any simultaneous reg_write SHALL be ignored.
REQ-027 During rst=1, rd_data_x SHALL still be combinational; bypass SHALL remain active (reflecting inputs), array contents become 0 at the edge.
REQ-028 First commit SHALL be possible at the first posedge with rst=0.

Structure
REQ-029 Shared package SHALL hold DATA_W/ADDR_W defaults, REG_ZERO index constant and the mem_to_reg select encoding.
REQ-030 One sub-module: wb_mux (2:1 write-data select); register array and bypass stay in wb_regfile.
REQ-031 Register array SHALL be a flat reg array with no reset-free inference assumptions beyond REQ-026.

Verification
REQ-032 Reset then read all 32 indices on both ports -> every rd_data = 0, wr_count=0, fwd_valid=0.
REQ-033 reg_write=1, mem_to_reg=0, wr_addr=5, alu_result=32'h1234_5678, rd_addr_a=5 same cycle -> rd_data_a=32'h1234_5678 before edge; after edge fwd_valid=1, fwd_addr=5, fwd_data=32'h1234_5678, wr_count=1.
REQ-034 reg_write=1, mem_to_reg=1, wr_addr=0, mem_data=32'hDEAD_BEEF -> rd_data for index 0 stays 0, wr_count unchanged, fwd_valid=0 next cycle.
REQ-035 Write r7=32'hA, next cycle write r7=32'hB with rd_addr_a=rd_addr_b=7 -> both ports read 32'hB in second cycle, 32'hB thereafter.
REQ-036 Assert rst with reg_write=1, wr_addr=3, alu_result=32'h55 -> after edge r3 reads 0, wr_count=0.
REQ-037 Commit 65536 writes to nonzero indices -> wr_count wraps to 0.
